// File: rtl/circle_tracker_pkg.sv
// circle_pkg: shared types and constants for the playfield circle tracker.
//   - state_t      : tracker FSM state encoding
//   - KEY_*        : USB HID keycodes for the four lanes (A, S, D, F)
//   - LANE_X_*     : screen column of each lane centre
//   - lane_lookup(): maps a 2-bit lane code to {x[9:0], key[7:0]}
package circle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [7:0] KEY_A = 8'd4;
  localparam logic [7:0] KEY_S = 8'd22;
  localparam logic [7:0] KEY_D = 8'd7;
  localparam logic [7:0] KEY_F = 8'd9;

  localparam logic [9:0] LANE_X_0 = 10'd160;
  localparam logic [9:0] LANE_X_1 = 10'd260;
  localparam logic [9:0] LANE_X_2 = 10'd380;
  localparam logic [9:0] LANE_X_3 = 10'd480;

  // Returns {x, key} for the given lane code.
  function automatic logic [17:0] lane_lookup(input logic [1:0] lane);
    logic [17:0] result;
    case (lane)
      2'd0:    result = {LANE_X_0, KEY_A};
      2'd1:    result = {LANE_X_1, KEY_S};
      2'd2:    result = {LANE_X_2, KEY_D};
      default: result = {LANE_X_3, KEY_F};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/circle_tracker_if.sv
// circle_tracker_if: handshake between the rhythm-game control FSM and the
// circle tracker.
//   spawn         : FSM -> tracker, one-cycle launch strobe
//   circletype    : FSM -> tracker, lane code sampled with spawn
//   reload        : FSM -> tracker, level, restores the initial health
//   out_of_bounds : tracker -> FSM, current circle resolved (hit or miss)
//   health        : tracker -> FSM, saturating score
interface circle_tracker_if;
  import circle_pkg::*;

  logic       spawn;
  logic [1:0] circletype;
  logic       reload;
  logic       out_of_bounds;
  logic [3:0] health;

  modport master (
    output spawn, circletype, reload,
    input  out_of_bounds, health
  );

  modport slave (
    input  spawn, circletype, reload,
    output out_of_bounds, health
  );

endinterface

// File: rtl/circle_tracker_key_edge.sv
// key_edge: rising-match detector for a target keycode.
//   Clk, Reset : clock and synchronous active-high reset
//   keycode    : current USB HID keycode
//   target     : keycode to watch for
//   press      : high for the cycle where keycode first equals target
module key_edge
  import circle_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] target,
  output logic       press
);

  logic [7:0] prev_key_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_key_reg <= 8'd0;
    end else begin
      prev_key_reg <= keycode;
    end
  end

  // Holding the key keeps prev == target, so no repeat press.
  assign press = (keycode == target) && (prev_key_reg != target);

endmodule

// File: rtl/circle_tracker.sv
// circle_tracker: animates one falling circle per spawn and judges the
// player's keypress against a hit window around HIT_Y.
//   Clk, Reset    : clock and synchronous active-high reset
//   frame_tick    : one-cycle pulse per video frame
//   keycode       : current USB HID keycode
//   bus (slave)   : spawn/circletype/reload in, out_of_bounds/health out
//   circle_active : circle should be drawn (state FALLING)
//   circle_x/y    : circle centre column / row
//   hit, miss     : one-cycle resolution pulses
module circle_tracker
  import circle_pkg::*;
#(
  parameter int SPEED       = 4,
  parameter int HIT_Y       = 400,
  parameter int WINDOW      = 16,
  parameter int BOTTOM      = 479,
  parameter int INIT_HEALTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic [7:0]       keycode,
  circle_tracker_if.slave  bus,
  output logic             circle_active,
  output logic [9:0]       circle_x,
  output logic [9:0]       circle_y,
  output logic             hit,
  output logic             miss
);

  localparam logic [10:0] WIN_LO   = 11'(HIT_Y - WINDOW);
  localparam logic [10:0] WIN_HI   = 11'(HIT_Y + WINDOW);
  localparam logic [10:0] Y_LIMIT  = 11'(BOTTOM);
  localparam logic [3:0]  HEALTH_0 = 4'(INIT_HEALTH);

  state_t      state_reg;
  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic [7:0]  lane_key_reg;
  logic [3:0]  health_reg;
  logic        hit_reg;
  logic        miss_reg;

  logic        press;
  logic [17:0] lane;
  logic [10:0] y_adv;
  logic        falling;
  logic        in_window;
  logic        hit_now;
  logic        miss_now;

  key_edge u_key_edge (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .target  (lane_key_reg),
    .press   (press)
  );

  assign lane      = lane_lookup(bus.circletype);
  // One extra bit so the bottom test cannot wrap.
  assign y_adv     = {1'b0, y_reg} + 11'(SPEED);
  assign falling   = (state_reg == ST_FALLING);
  assign in_window = ({1'b0, y_reg} >= WIN_LO) && ({1'b0, y_reg} <= WIN_HI);
  // A press is judged against the registered y, so it beats a same-cycle tick.
  assign hit_now   = falling && press && in_window;
  assign miss_now  = falling && frame_tick && !hit_now && (y_adv > Y_LIMIT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      x_reg        <= 10'd0;
      y_reg        <= 10'd0;
      lane_key_reg <= 8'd0;
      health_reg   <= HEALTH_0;
      hit_reg      <= 1'b0;
      miss_reg     <= 1'b0;
    end else begin
      hit_reg  <= 1'b0;
      miss_reg <= 1'b0;
      if (bus.reload) begin
        health_reg <= HEALTH_0;
        state_reg  <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (bus.spawn) begin
              x_reg        <= lane[17:8];
              lane_key_reg <= lane[7:0];
              y_reg        <= 10'd0;
              state_reg    <= ST_FALLING;
            end
          end
          ST_FALLING: begin
            if (hit_now) begin
              hit_reg    <= 1'b1;
              health_reg <= (health_reg == 4'd15) ? health_reg : health_reg + 4'd1;
              state_reg  <= ST_DONE;
            end else if (miss_now) begin
              miss_reg   <= 1'b1;
              health_reg <= (health_reg == 4'd0) ? health_reg : health_reg - 4'd1;
              state_reg  <= ST_DONE;
            end else if (frame_tick) begin
              y_reg <= y_adv[9:0];
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign circle_active     = (state_reg == ST_FALLING);
  assign bus.out_of_bounds = (state_reg == ST_DONE);
  assign bus.health        = health_reg;
  assign circle_x          = x_reg;
  assign circle_y          = y_reg;
  assign hit               = hit_reg;
  assign miss              = miss_reg;

endmodule

// File: tb/tb_circle_tracker.sv
// tb_circle_tracker: directed test of circle_tracker with hand-computed
// expected values for miss, hit, window edges, saturation, priority and reset.
module tb_circle_tracker;
  import circle_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       circle_active;
  logic [9:0] circle_x;
  logic [9:0] circle_y;
  logic       hit;
  logic       miss;

  int checks = 0;
  int errors = 0;
  logic hit_seen;

  circle_tracker_if bus ();

  circle_tracker dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .keycode       (keycode),
    .bus           (bus.slave),
    .circle_active (circle_active),
    .circle_x      (circle_x),
    .circle_y      (circle_y),
    .hit           (hit),
    .miss          (miss)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (hit) hit_seen = 1'b1;
    step();
    if (hit) hit_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic spawn_lane(input logic [1:0] lane);
    bus.spawn      = 1'b1;
    bus.circletype = lane;
    step();
    bus.spawn      = 1'b0;
  endtask

  task automatic press_key(input logic [7:0] key);
    keycode = key;
    step();
    keycode = 8'd0;
  endtask

  // Full hit on lane 3 (F): 100 ticks reaches y = 400.
  task automatic run_hit();
    spawn_lane(2'd3);
    ticks(100);
    press_key(KEY_F);
    step();
  endtask

  // Full miss on lane 0: 119 ticks to y = 476, the 120th resolves.
  task automatic run_miss();
    spawn_lane(2'd0);
    ticks(120);
    step();
  endtask

  initial begin
    Reset          = 1'b1;
    frame_tick     = 1'b0;
    keycode        = 8'd0;
    bus.spawn      = 1'b0;
    bus.circletype = 2'd0;
    bus.reload     = 1'b0;
    hit_seen       = 1'b0;
    step();
    step();
    Reset = 1'b0;

    // Reset state
    check("rst_oob",    32'(bus.out_of_bounds), 0);
    check("rst_active", 32'(circle_active),     0);
    check("rst_health", 32'(bus.health),        3);
    check("rst_x",      32'(circle_x),          0);
    check("rst_y",      32'(circle_y),          0);
    check("rst_hit",    32'(hit),               0);
    check("rst_miss",   32'(miss),              0);

    // Miss on lane 01
    spawn_lane(2'd1);
    check("miss_spawn_active", 32'(circle_active), 1);
    check("miss_spawn_y",      32'(circle_y),      0);
    check("miss_spawn_x",      32'(circle_x),      260);
    ticks(119);
    check("miss_y476",  32'(circle_y), 476);
    check("miss_early", 32'(miss),     0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("miss_pulse",  32'(miss),              1);
    check("miss_health", 32'(bus.health),        2);
    check("miss_oob",    32'(bus.out_of_bounds), 1);
    check("miss_y_hold", 32'(circle_y),          476);
    step();
    check("miss_pulse_end", 32'(miss), 0);
    ticks(5);
    check("miss_oob_stay", 32'(bus.out_of_bounds), 1);
    check("miss_x",        32'(circle_x),          260);
    check("miss_active",   32'(circle_active),     0);

    // Reload back to initial health
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    check("reload_health", 32'(bus.health),        3);
    check("reload_oob",    32'(bus.out_of_bounds), 0);

    // Hit on lane 10, with an ignored spawn mid-flight
    spawn_lane(2'd2);
    check("hit_x", 32'(circle_x), 380);
    ticks(10);
    bus.spawn      = 1'b1;
    bus.circletype = 2'd0;
    frame_tick     = 1'b1;
    step();
    bus.spawn  = 1'b0;
    frame_tick = 1'b0;
    check("spawn_ign_y", 32'(circle_y), 44);
    check("spawn_ign_x", 32'(circle_x), 380);
    step();
    ticks(88);
    check("hit_y396", 32'(circle_y), 396);
    press_key(KEY_D);
    check("hit_pulse",  32'(hit),               1);
    check("hit_health", 32'(bus.health),        4);
    check("hit_oob",    32'(bus.out_of_bounds), 1);
    step();
    check("hit_pulse_end", 32'(hit), 0);

    // Window upper edge y = 416 is a hit
    spawn_lane(2'd2);
    ticks(104);
    check("edge416_y", 32'(circle_y), 416);
    press_key(KEY_D);
    check("edge416_hit",    32'(hit),        1);
    check("edge416_health", 32'(bus.health), 5);
    step();

    // y = 420 is outside: ignored, then miss
    spawn_lane(2'd2);
    ticks(105);
    check("edge420_y", 32'(circle_y), 420);
    press_key(KEY_D);
    check("edge420_hit",    32'(hit),           0);
    check("edge420_active", 32'(circle_active), 1);
    ticks(14);
    check("edge420_y476", 32'(circle_y), 476);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("edge420_miss",   32'(miss),       1);
    check("edge420_health", 32'(bus.health), 4);
    step();

    // Holding the key from y = 380 never hits
    spawn_lane(2'd2);
    ticks(95);
    check("hold_y380", 32'(circle_y), 380);
    keycode  = KEY_D;
    hit_seen = 1'b0;
    step();
    if (hit) hit_seen = 1'b1;
    ticks(24);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("hold_miss",    32'(miss),       1);
    check("hold_no_hit",  32'(hit_seen),   0);
    check("hold_health",  32'(bus.health), 3);
    keycode = 8'd0;
    step();

    // Saturation at 15
    for (int i = 0; i < 12; i++) run_hit();
    check("sat_hi_pre", 32'(bus.health), 15);
    check("lane3_x",    32'(circle_x),   480);
    spawn_lane(2'd3);
    ticks(100);
    press_key(KEY_F);
    check("sat_hi_hit",    32'(hit),        1);
    check("sat_hi_health", 32'(bus.health), 15);
    step();

    // Saturation at 0
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    for (int i = 0; i < 3; i++) run_miss();
    check("sat_lo_pre", 32'(bus.health), 0);
    check("lane0_x",    32'(circle_x),   160);
    spawn_lane(2'd0);
    ticks(119);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("sat_lo_miss",   32'(miss),       1);
    check("sat_lo_health", 32'(bus.health), 0);
    step();

    // Reload in the same cycle as a hit
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    check("reload2_health", 32'(bus.health), 3);
    spawn_lane(2'd2);
    ticks(100);
    keycode    = KEY_D;
    bus.reload = 1'b1;
    step();
    keycode    = 8'd0;
    bus.reload = 1'b0;
    check("prio_health", 32'(bus.health),        3);
    check("prio_hit",    32'(hit),               0);
    check("prio_oob",    32'(bus.out_of_bounds), 0);
    check("prio_active", 32'(circle_active),     0);

    // Reset mid-flight
    spawn_lane(2'd1);
    ticks(50);
    check("midrst_y200", 32'(circle_y), 200);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_active", 32'(circle_active),     0);
    check("midrst_oob",    32'(bus.out_of_bounds), 0);
    check("midrst_x",      32'(circle_x),          0);
    check("midrst_y",      32'(circle_y),          0);
    check("midrst_health", 32'(bus.health),        3);
    check("midrst_hit",    32'(hit),               0);
    check("midrst_miss",   32'(miss),              0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/circle_tracker.md
# circle_tracker

Playfield responder for the rhythm-game control FSM. It consumes the FSM's one-cycle `spawn` strobe and `circletype` lane code, animates one falling circle per frame tick, and judges the player's keypress against a hit window. It reports resolution back through `out_of_bounds` and maintains the running `health` score that the FSM reads in its `finished` state. Its position outputs feed the colour mapper.

## Interface
- `SPEED`, 4: pixels the circle descends per frame tick.
- `HIT_Y`, 400: centre row of the hit line.
- `WINDOW`, 16: half-width of the hit window, in pixels.
- `BOTTOM`, 479: last visible row; a circle past this row is a miss.
- `INIT_HEALTH`, 3: health value after reset or reload.

- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame, synchronous to `Clk`.
- `reload`, in, 1: level input, driven by FSM `main`; restores `INIT_HEALTH`.
- `spawn`, in, 1: one-cycle launch strobe from the FSM.
- `circletype`, in, 2: lane select, sampled when `spawn` is high.
- `keycode`, in, 8: current USB HID keycode.
- `out_of_bounds`, out, 1: level; the current circle is resolved as either hit or miss.
- `health`, out, 4: saturating score.
- `circle_active`, out, 1: a circle should be drawn.
- `circle_x`, out, 10: circle centre column.
- `circle_y`, out, 10: circle centre row.
- `hit`, out, 1: one-cycle pulse on a successful hit.
- `miss`, out, 1: one-cycle pulse on a miss.

## Operation
- **States:**
  - `IDLE`: the reset state.
  - `FALLING`: a circle is in flight.
  - `DONE`: the circle has been resolved.
- **Lane table**, indexed by `circletype`:
  - 00: x=160, key `A` (8'd4).
  - 01: x=260, key `S` (8'd22).
  - 10: x=380, key `D` (8'd7).
  - 11: x=480, key `F` (8'd9).
- **IDLE / DONE + `spawn`:**
  - Latch the lane and set `circle_x` from the table.
  - Set `circle_y` to 0.
  - Go to `FALLING`.
- **FALLING:**
  - On `frame_tick`, `circle_y` increases by `SPEED`.
  - If `circle_y + SPEED > BOTTOM` (computed at 11 bits, so no wrap), do not update y. Instead pulse `miss`, decrement `health` (saturating at 0), and go to `DONE`.
- **Key judging:**
  - A press is a rising match: `keycode` equals the lane key this cycle and did not equal it the previous cycle.
  - Holding the key gives no repeat. A non-matching keycode is ignored and carries no penalty.
- **Hit:**
  - Condition: a press arrives in `FALLING` while `|circle_y − HIT_Y| ≤ WINDOW`.
  - Response: pulse `hit`, increment `health` (saturating at 15), and go to `DONE`.
  - A press outside the window is ignored.
- **Same-cycle press and tick:** the press is judged against the registered y; the hit wins and y is not advanced.
- **`spawn` while FALLING:** ignored; one circle at a time.
- **DONE:**
  - `out_of_bounds` = 1 and `circle_active` = 0.
  - The state holds until the next `spawn`, or until `reload`.
- **`reload`:**
  - Sets `health` to `INIT_HEALTH` and the state to `IDLE`.
  - It takes priority over `spawn`, hit and miss.
- **Output mapping:**
  - `circle_active` = (state == `FALLING`).
  - `out_of_bounds` = (state == `DONE`).

## Timing
- **Reset values:**
  - State `IDLE`.
  - `health` = `INIT_HEALTH`.
  - `circle_x` = `circle_y` = 0.
  - `out_of_bounds`, `circle_active`, `hit` and `miss` all 0.
  - Key-history register cleared to 8'd0.
- **`spawn` latency:** `spawn` at cycle N gives `circle_active` = 1 and y = 0 at N+1.
- **Resolution latency:**
  - Hit or miss detected at cycle N gives the `hit`/`miss` pulse, the health update and `out_of_bounds` = 1, all visible at N+1.
  - The `hit`/`miss` pulse lasts exactly one cycle.
- **`Reset` mid-flight:** returns every output to its reset value on the next edge.

## Structure
- **Package `circle_pkg`** holds:
  - the state enum;
  - the four lane keycode constants;
  - the lane x constants;
  - the lane-lookup function returning {x, key}.
- **Sub-module `key_edge`:**
  - Registers the previous keycode.
  - Outputs a `press` pulse for a given target key.
  - Instantiated once, with the latched lane key as the target.

## Test plan
- **Miss:** reset, `spawn` with `circletype`=01, then 120 frame ticks with no key.
  - `miss` pulses once and `health` goes 3→2.
  - `out_of_bounds` goes to 1 and stays there; `circle_x` = 260.
- **Hit:** `spawn` with `circletype`=10, ticks until y = 396, then `keycode` 7.
  - `hit` pulses and `health` goes 3→4.
  - `out_of_bounds` = 1 on the next cycle.
- **Window edges:**
  - Press at y = 416 is a hit.
  - Press at y = 420 is ignored, and the circle continues to a miss.
  - Holding key 7 from y = 380 gives no hit.
- **Saturation:**
  - From health 15, one more hit leaves health at 15.
  - From health 0, one more miss leaves health at 0.
- **Priority:**
  - `spawn` during `FALLING` is ignored, and y keeps advancing.
  - `reload` in the same cycle as a hit gives health = 3, state `IDLE` and no `hit` pulse.
- **Reset mid-flight:** `Reset` at y = 200 gives all outputs at their reset values on the next cycle.
